// File: rtl/clk_track_pkg.sv
// Shared types and width helpers for the divided-clock tracker.
package clk_track_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } track_state_e;

    localparam int unsigned ERR_W  = 8;
    localparam int unsigned GOOD_W = 4;

    function automatic int unsigned cnt_width(input int unsigned div);
        return $clog2(2 * div);
    endfunction

    function automatic int unsigned phase_width(input int unsigned div);
        return $clog2(div);
    endfunction

endpackage

// File: rtl/div_clk_tracker_if.sv
// Slow-clock input and tracker status bundle; master drives slow_in, slave is the tracker.
interface div_clk_tracker_if #(parameter int unsigned DIV = 8);
    import clk_track_pkg::*;

    localparam int unsigned PW = phase_width(DIV);

    logic             slow_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             locked;
    logic [PW-1:0]    phase;
    logic             period_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output slow_in,
        input  rise_pulse, fall_pulse, locked, phase, period_err, err_count
    );

    modport slave (
        input  slow_in,
        output rise_pulse, fall_pulse, locked, phase, period_err, err_count
    );

endinterface

// File: rtl/div_clk_tracker_sync_edge.sv
// Three-flop synchroniser with edge detect and registered rise/fall strobes.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic       s1, s2, s3;
    logic [1:0] fill;
    logic       armed;
    logic       fall_c;

    // Reset zeros in s2/s3 are not real samples: strobes stay off until a genuine low reaches s3.
    assign rise_c = armed & s2 & ~s3;
    assign fall_c = armed & ~s2 & s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            fill       <= 2'b00;
            armed      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            s1         <= din;
            s2         <= s1;
            s3         <= s2;
            fill       <= {fill[0], 1'b1};
            armed      <= armed | (fill[1] & ~s2);
            rise_pulse <= rise_c;
            fall_pulse <= fall_c;
        end
    end

endmodule

// File: rtl/div_clk_tracker.sv
// Tracks a divided slow clock in the fast domain: strobes, period check, lock FSM, phase.
module div_clk_tracker
    import clk_track_pkg::*;
#(
    parameter int unsigned DIV        = 8,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    div_clk_tracker_if.slave bus
);

    localparam int unsigned     CW      = cnt_width(DIV);
    localparam int unsigned     PW      = phase_width(DIV);
    localparam int unsigned     PERW    = CW + 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(2 * DIV - 1);

    logic             rise_det_c;
    logic             rise_pulse_q;
    logic             fall_pulse_q;

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next_c;
    logic [PERW-1:0]  period_c;
    logic             period_ok_c;
    logic             timeout_c;

    track_state_e     state;
    track_state_e     state_next_c;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_next_c;
    logic             err_c;

    logic             locked_q;
    logic [PW-1:0]    phase_q;
    logic             period_err_q;
    logic [ERR_W-1:0] err_count_q;

    sync_edge u_sync (
        .clk        (clk),
        .reset      (reset),
        .din        (bus.slow_in),
        .rise_c     (rise_det_c),
        .rise_pulse (rise_pulse_q),
        .fall_pulse (fall_pulse_q)
    );

    // Period counter restarts on each rise and parks at its maximum.
    always_comb begin
        cnt_next_c = cnt;
        if (rise_det_c) begin
            cnt_next_c = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_next_c = cnt + CW'(1);
        end
    end

    assign period_c    = PERW'(cnt) + PERW'(1);
    assign period_ok_c = (period_c == PERW'(DIV));
    assign timeout_c   = (cnt == CNT_MAX) && !rise_det_c;

    // Lock FSM next state; a rise coincident with saturation is a bad period, not a timeout.
    always_comb begin
        state_next_c = state;
        good_next_c  = good;
        err_c        = 1'b0;
        unique case (state)
            UNLOCKED: begin
                if (rise_det_c) begin
                    state_next_c = ACQUIRE;
                    good_next_c  = '0;
                end
            end
            ACQUIRE: begin
                if (rise_det_c) begin
                    if (period_ok_c) begin
                        if (good == GOOD_W'(LOCK_COUNT - 1)) begin
                            state_next_c = LOCKED;
                            good_next_c  = '0;
                        end else begin
                            good_next_c = good + GOOD_W'(1);
                        end
                    end else begin
                        good_next_c = '0;
                        err_c       = 1'b1;
                    end
                end else if (timeout_c) begin
                    state_next_c = UNLOCKED;
                    good_next_c  = '0;
                    err_c        = 1'b1;
                end
            end
            LOCKED: begin
                if (rise_det_c) begin
                    if (!period_ok_c) begin
                        state_next_c = ACQUIRE;
                        good_next_c  = '0;
                        err_c        = 1'b1;
                    end
                end else if (timeout_c) begin
                    state_next_c = UNLOCKED;
                    good_next_c  = '0;
                    err_c        = 1'b1;
                end
            end
            default: begin
                state_next_c = UNLOCKED;
                good_next_c  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= UNLOCKED;
            good         <= '0;
            cnt          <= '0;
            locked_q     <= 1'b0;
            phase_q      <= '0;
            period_err_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state        <= state_next_c;
            good         <= good_next_c;
            cnt          <= cnt_next_c;
            locked_q     <= (state_next_c == LOCKED);
            phase_q      <= (state_next_c == LOCKED) ? cnt_next_c[PW-1:0] : '0;
            period_err_q <= err_c;
            if (err_c && (err_count_q != '1)) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end
        end
    end

    assign bus.rise_pulse = rise_pulse_q;
    assign bus.fall_pulse = fall_pulse_q;
    assign bus.locked     = locked_q;
    assign bus.phase      = phase_q;
    assign bus.period_err = period_err_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_div_clk_tracker.sv
// Directed bench for div_clk_tracker: lock, bad period, timeout, async reset, saturation, DIV=4.
module tb_div_clk_tracker;

    typedef struct packed {
        logic       rp;
        logic       fp;
        logic       lk;
        logic       pe;
        logic [2:0] ph;
        logic [7:0] ec;
    } obs_t;

    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    obs_t log_a [LOGN];
    obs_t log_b [LOGN];

    div_clk_tracker_if #(.DIV(8)) if_a ();
    div_clk_tracker_if #(.DIV(4)) if_b ();

    div_clk_tracker #(.DIV(8), .LOCK_COUNT(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    div_clk_tracker #(.DIV(4), .LOCK_COUNT(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot after edge cyc, taken on the falling edge.
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_a[cyc] = {if_a.rise_pulse, if_a.fall_pulse, if_a.locked, if_a.period_err,
                          3'(if_a.phase), if_a.err_count};
            log_b[cyc] = {if_b.rise_pulse, if_b.fall_pulse, if_b.locked, if_b.period_err,
                          3'(if_b.phase), if_b.err_count};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input bit sel_b, input logic lvl, input int n);
        if (sel_b) if_b.slow_in = lvl;
        else       if_a.slow_in = lvl;
        repeat (n) tick();
    endtask

    function automatic int count_rp_a(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(log_a[i].rp);
        return n;
    endfunction

    function automatic int count_pe_a(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(log_a[i].pe);
        return n;
    endfunction

    int t_rise [6];
    int t_g    [5];
    int t4     [6];
    int t_b    [4];
    int tb0, tr, tl, tq, t0;

    initial begin
        reset        = 1'b1;
        if_a.slow_in = 1'b0;
        if_b.slow_in = 1'b0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_rise_pulse", 32'(if_a.rise_pulse), 0);
        check_eq("rst_fall_pulse", 32'(if_a.fall_pulse), 0);
        check_eq("rst_locked",     32'(if_a.locked), 0);
        check_eq("rst_phase",      32'(if_a.phase), 0);
        check_eq("rst_period_err", 32'(if_a.period_err), 0);
        check_eq("rst_err_count",  32'(if_a.err_count), 0);
        reset = 1'b0;

        // Lock acquire: 4/4 toggling, first rise 10 cycles after release
        hold(0, 1'b0, 10);
        for (int p = 0; p < 6; p++) begin
            t_rise[p] = cyc;
            hold(0, 1'b1, 4);
            hold(0, 1'b0, 4);
        end
        check_eq("lock_rise_latency_pre", 32'(log_a[t_rise[0] + 2].rp), 0);
        check_eq("lock_rise_latency",     32'(log_a[t_rise[0] + 3].rp), 1);
        check_eq("lock_fall_latency",     32'(log_a[t_rise[0] + 7].fp), 1);
        for (int p = 1; p < 6; p++)
            check_eq($sformatf("lock_rise_%0d", p), 32'(log_a[t_rise[p] + 3].rp), 1);
        check_eq("lock_rise_total", 32'(count_rp_a(t_rise[0], t_rise[5] + 7)), 6);
        check_eq("lock_not_at_4th",   32'(log_a[t_rise[3] + 3].lk), 0);
        check_eq("lock_before_5th",   32'(log_a[t_rise[4] + 2].lk), 0);
        check_eq("lock_at_5th",       32'(log_a[t_rise[4] + 3].lk), 1);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("lock_phase_%0d", i), 32'(log_a[t_rise[4] + 3 + i].ph), 32'(i));
        check_eq("lock_no_err",    32'(count_pe_a(t_rise[0], t_rise[5] + 7)), 0);
        check_eq("lock_err_count", 32'(log_a[cyc - 1].ec), 0);

        // Bad period: one low half stretched to 5 cycles, then relock
        tb0 = cyc;
        hold(0, 1'b1, 4);
        hold(0, 1'b0, 5);
        tr = cyc;
        hold(0, 1'b1, 4);
        hold(0, 1'b0, 4);
        for (int k = 1; k < 5; k++) begin
            t_g[k] = cyc;
            hold(0, 1'b1, 4);
            hold(0, 1'b0, 4);
        end
        check_eq("bad_good_rise_locked", 32'(log_a[tb0 + 3].lk), 1);
        check_eq("bad_err_strobe",   32'(log_a[tr + 3].pe), 1);
        check_eq("bad_err_one_cyc",  32'(log_a[tr + 4].pe), 0);
        check_eq("bad_locked_pre",   32'(log_a[tr + 2].lk), 1);
        check_eq("bad_locked_drop",  32'(log_a[tr + 3].lk), 0);
        check_eq("bad_err_count",    32'(log_a[tr + 3].ec), 1);
        check_eq("bad_phase_unlocked", 32'(log_a[tr + 5].ph), 0);
        check_eq("relock_not_yet",   32'(log_a[t_g[3] + 3].lk), 0);
        check_eq("relock",           32'(log_a[t_g[4] + 3].lk), 1);

        // Timeout: last rise then slow_in held low
        tl = cyc;
        hold(0, 1'b1, 4);
        hold(0, 1'b0, 40);
        check_eq("to_pe_pre",      32'(log_a[tl + 18].pe), 0);
        check_eq("to_pe",          32'(log_a[tl + 19].pe), 1);
        check_eq("to_locked_pre",  32'(log_a[tl + 18].lk), 1);
        check_eq("to_locked_drop", 32'(log_a[tl + 19].lk), 0);
        check_eq("to_pe_once",     32'(count_pe_a(tl, tl + 42)), 1);
        check_eq("to_err_count",   32'(log_a[tl + 19].ec), 2);
        check_eq("to_no_rise",     32'(count_rp_a(tl + 4, tl + 42)), 0);

        // Reset mid-lock with slow_in high at release
        for (int p = 0; p < 6; p++) begin
            t4[p] = cyc;
            hold(0, 1'b1, 4);
            hold(0, 1'b0, 4);
        end
        check_eq("rl_relocked", 32'(log_a[t4[4] + 3].lk), 1);
        hold(0, 1'b1, 2);
        check_eq("rl_pre_locked",    32'(if_a.locked), 1);
        check_eq("rl_pre_err_count", 32'(if_a.err_count), 2);
        #3;
        reset = 1'b1;
        #1;
        check_eq("rl_async_locked",    32'(if_a.locked), 0);
        check_eq("rl_async_err_count", 32'(if_a.err_count), 0);
        check_eq("rl_async_phase",     32'(if_a.phase), 0);
        check_eq("rl_async_outs",
                 32'({if_a.rise_pulse, if_a.fall_pulse, if_a.period_err}), 0);
        repeat (2) tick();
        reset = 1'b0;
        tq = cyc;
        hold(0, 1'b1, 10);
        hold(0, 1'b0, 4);
        t0 = cyc;

        // Saturation: 260 bad periods (period 9) while acquiring
        for (int n = 0; n < 261; n++) begin
            hold(0, 1'b1, 4);
            hold(0, 1'b0, 5);
        end
        check_eq("rl_no_rise_high_release", 32'(count_rp_a(tq, t0 + 2)), 0);
        check_eq("rl_first_real_rise",      32'(log_a[t0 + 3].rp), 1);
        check_eq("sat_pe_total",  32'(count_pe_a(t0 + 1, t0 + 2348)), 260);
        check_eq("sat_ec_254",    32'(log_a[t0 + 9 * 254 + 3].ec), 254);
        check_eq("sat_ec_255",    32'(log_a[t0 + 9 * 255 + 3].ec), 255);
        check_eq("sat_ec_hold",   32'(log_a[t0 + 9 * 260 + 3].ec), 255);
        check_eq("sat_pe_last",   32'(log_a[t0 + 9 * 260 + 3].pe), 1);

        // DIV=4, LOCK_COUNT=1
        for (int p = 0; p < 4; p++) begin
            t_b[p] = cyc;
            hold(1, 1'b1, 2);
            hold(1, 1'b0, 2);
        end
        hold(1, 1'b0, 4);
        check_eq("d4_rise1",          32'(log_b[t_b[0] + 3].rp), 1);
        check_eq("d4_unlocked_1st",   32'(log_b[t_b[0] + 3].lk), 0);
        check_eq("d4_locked_pre_2nd", 32'(log_b[t_b[1] + 2].lk), 0);
        check_eq("d4_locked_2nd",     32'(log_b[t_b[1] + 3].lk), 1);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("d4_phase_%0d", i), 32'(log_b[t_b[1] + 3 + i].ph), 32'(i));
        check_eq("d4_phase_wrap",  32'(log_b[t_b[2] + 3].ph), 0);
        check_eq("d4_still_locked", 32'(log_b[t_b[3] + 3].lk), 1);
        check_eq("d4_err_count",    32'(log_b[t_b[3] + 3].ec), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
